// File: rtl/acq_sequencer.sv
// Acquisition start/stop sequencer: counts masked event edges to open and close a capture window.
// Optional wait timeout is compiled in when ACQ_TIMEOUT_EN is defined.
module acq_sequencer #(
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TMO_W   = 16
) (
    input  logic               CLK_MASTER,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [NUM_EVT-1:0] EVT_IN,
    input  logic [NUM_EVT-1:0] START_MASK,
    input  logic [NUM_EVT-1:0] STOP_MASK,
    input  logic [CNT_W-1:0]   START_NUM,
    input  logic [CNT_W-1:0]   STOP_NUM,
    input  logic               START_QUAL_EN,
    input  logic               START_QUAL,
    input  logic               STOP_QUAL_EN,
    input  logic               STOP_QUAL,
    input  logic               SR_R_FULL,
    input  logic               CKE_TICK,
    input  logic [TMO_W-1:0]   TIMEOUT_LIMIT,
    output logic               WAITING,
    output logic               ACQUIRING,
    output logic               DONE,
    output logic [1:0]         STATUS,
    output logic [CNT_W-1:0]   SCOUNT,
    output logic [CNT_W-1:0]   ECOUNT
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSqual = 3'd1,
        StWait  = 3'd2,
        StEqual = 3'd3,
        StAcq   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_EVT-1:0] evt_d_q;
    logic [CNT_W-1:0]   scount_q, scount_d, ecount_q, ecount_d;
    logic [1:0]         status_q, status_d;
    logic               done_q, done_d;
    logic [NUM_EVT-1:0] edge_v;
    logic               start_go, stop_go;

    // An empty mask means "count every cycle" rather than "never count".
    assign edge_v   = EVT_IN & ~evt_d_q;
    assign start_go = (START_MASK == '0) || ((edge_v & START_MASK) != '0);
    assign stop_go  = (STOP_MASK == '0) || ((edge_v & STOP_MASK) != '0);

`ifdef ACQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^{CKE_TICK, TIMEOUT_LIMIT};
`endif

    always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            evt_d_q  <= '0;
            scount_q <= '0;
            ecount_q <= '0;
            status_q <= 2'b00;
            done_q   <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            evt_d_q  <= EVT_IN;
            scount_q <= scount_d;
            ecount_q <= ecount_d;
            status_q <= status_d;
            done_q   <= done_d;
`ifdef ACQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        scount_d = scount_q;
        ecount_d = ecount_q;
        status_d = status_q;
        done_d   = 1'b0;
`ifdef ACQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        if (ABORT) begin
            state_d  = StIdle;
            status_d = 2'b00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (START) begin
                        scount_d = START_NUM;
                        ecount_d = STOP_NUM;
                        status_d = 2'b00;
                        state_d  = START_QUAL_EN ? StSqual : StWait;
`ifdef ACQ_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end
                end
                StSqual: if (START_QUAL) state_d = StWait;
                StWait: begin
                    if (start_go) begin
                        if (scount_q != '0) scount_d = scount_q - CNT_W'(1);
                        else                state_d  = STOP_QUAL_EN ? StEqual : StAcq;
                    end
                end
                StEqual: if (STOP_QUAL) state_d = StAcq;
                StAcq: begin
                    if (SR_R_FULL) begin
                        state_d  = StIdle;
                        status_d = 2'b10;
                        done_d   = 1'b1;
                    end else if (stop_go) begin
                        if (ecount_q != '0) begin
                            ecount_d = ecount_q - CNT_W'(1);
                        end else begin
                            state_d  = StIdle;
                            status_d = 2'b01;
                            done_d   = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
`ifdef ACQ_TIMEOUT_EN
            // Timeout only fires if the start side did not move this cycle.
            if (state_q == StSqual || state_q == StWait) begin
                if (CKE_TICK && tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
                if (state_d == state_q && TIMEOUT_LIMIT != '0 && tmo_d >= TIMEOUT_LIMIT) begin
                    state_d  = StIdle;
                    status_d = 2'b11;
                    done_d   = 1'b1;
                end
            end
`endif
        end
    end

    always_comb begin
        WAITING   = 1'b0;
        ACQUIRING = 1'b0;
        case (state_q)
            StSqual, StWait: WAITING   = 1'b1;
            StEqual, StAcq:  ACQUIRING = 1'b1;
            default: ;
        endcase
        DONE   = done_q;
        STATUS = status_q;
        SCOUNT = scount_q;
        ECOUNT = ecount_q;
    end

endmodule
